// File: rtl/lamp_prob.sv
// lamp_prob: lamp-panel safety monitor.
// Synchronizes the enable and three fault sensors, classifies them into
// OFF / OK / ALERT / DANGER, persistence-filters the class, latches DANGER
// until the system is switched off, and drives three one-hot status lamps
// from flops.
module lamp_prob #(
    parameter int PERSIST = 4               // 1..255 cycles a new class must hold
) (
    input  logic clk,
    input  logic rst,
    input  logic l,
    input  logic t,
    input  logic p,
    input  logic s,
    output logic ok,
    output logic alert,
    output logic danger
);

    localparam int CW = $clog2(PERSIST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(PERSIST);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        CLS_OFF    = 2'd0,
        CLS_OK     = 2'd1,
        CLS_ALERT  = 2'd2,
        CLS_DANGER = 2'd3
    } cls_t;

    // Synchronizer stages, bit order {l, t, p, s}.
    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;

    logic          w_l_s;
    logic          w_t_s;
    logic          w_p_s;
    logic          w_s_s;
    logic [1:0]    w_nfault;
    cls_t          w_cand;

    // Filter and accepted-class state (the accepted class is the FSM state).
    cls_t          r_pend;
    logic [CW-1:0] r_cnt;
    cls_t          r_acc;
    cls_t          w_pend_nxt;
    logic [CW-1:0] w_cnt_nxt;
    cls_t          w_acc_nxt;

    // Lamp flops.
    logic          r_ok;
    logic          r_alert;
    logic          r_danger;

    // Two-flop synchronizers for every asynchronous input.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, giving a true 2-stage chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {l, t, p, s};
            r_sync2 <= r_sync1;
        end
    end

    assign w_l_s    = r_sync2[3];
    assign w_t_s    = r_sync2[2];
    assign w_p_s    = r_sync2[1];
    assign w_s_s    = r_sync2[0];
    assign w_nfault = {1'b0, w_t_s} + {1'b0, w_p_s} + {1'b0, w_s_s};

    // Candidate class from the synchronized inputs.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_cand = CLS_OFF;
        if (w_l_s) begin
            case (w_nfault)
                2'd0:    w_cand = CLS_OK;
                2'd1:    w_cand = CLS_ALERT;
                default: w_cand = CLS_DANGER;
            endcase
        end
    end

    // Next-state: persistence filter, OFF override and danger latch.
    always_comb begin
        w_pend_nxt = r_pend;
        w_cnt_nxt  = r_cnt;
        w_acc_nxt  = r_acc;
        if (w_cand == CLS_OFF) begin
            // OFF bypasses the filter and releases the danger latch.
            w_pend_nxt = CLS_OFF;
            w_cnt_nxt  = CNT_MAX;
            w_acc_nxt  = CLS_OFF;
        end else begin
            if (w_cand != r_pend) begin
                w_pend_nxt = w_cand;
                w_cnt_nxt  = CNT_ONE;
            end else if (r_cnt != CNT_MAX) begin
                w_cnt_nxt  = r_cnt + CNT_ONE;
            end
            // A class is accepted on the edge its count reaches PERSIST;
            // a latched DANGER only leaves through the OFF branch above.
            if ((w_cnt_nxt == CNT_MAX) && (r_acc != CLS_DANGER)) begin
                w_acc_nxt = w_pend_nxt;
            end
        end
    end

    // Filter and accepted-class registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= CLS_OFF;
            r_cnt  <= '0;
            r_acc  <= CLS_OFF;
        end else begin
            r_pend <= w_pend_nxt;
            r_cnt  <= w_cnt_nxt;
            r_acc  <= w_acc_nxt;
        end
    end

    // Registered one-hot lamp decode of the accepted class.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ok     <= 1'b0;
            r_alert  <= 1'b0;
            r_danger <= 1'b0;
        end else begin
            r_ok     <= (r_acc == CLS_OK);
            r_alert  <= (r_acc == CLS_ALERT);
            r_danger <= (r_acc == CLS_DANGER);
        end
    end

    assign ok     = r_ok;
    assign alert  = r_alert;
    assign danger = r_danger;

endmodule

// File: tb/tb_lamp_prob.sv
// tb_lamp_prob: directed, table-driven bench for lamp_prob with PERSIST = 4.
// Outputs are compared as {ok, alert, danger}; inputs change and outputs are
// sampled 1 ns after each rising edge.
module tb_lamp_prob;

    localparam int P = 4;

    localparam logic [2:0] O_NONE   = 3'b000;
    localparam logic [2:0] O_OK     = 3'b100;
    localparam logic [2:0] O_ALERT  = 3'b010;
    localparam logic [2:0] O_DANGER = 3'b001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic l   = 1'b0;
    logic t   = 1'b0;
    logic p   = 1'b0;
    logic s   = 1'b0;
    logic ok;
    logic alert;
    logic danger;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       l;
        logic       t;
        logic       p;
        logic       s;
        int         hold;      // cycles the inputs are held
        int         chk_from;  // first cycle index of the window that is checked
        logic [2:0] exp;       // expected {ok, alert, danger}
        string      name;
    } vec_t;

    vec_t vecs[13];

    lamp_prob #(.PERSIST(P)) dut (
        .clk    (clk),
        .rst    (rst),
        .l      (l),
        .t      (t),
        .p      (p),
        .s      (s),
        .ok     (ok),
        .alert  (alert),
        .danger (danger)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] exp);
        logic [2:0] act;
        act = {ok, alert, danger};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got ok/alert/danger=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vl, input logic vt, input logic vp, input logic vs);
        l = vl;
        t = vt;
        p = vp;
        s = vs;
    endtask

    // Release reset with l=1 and no faults; ok must rise exactly at edge 2+P.
    task automatic power_up(input string name);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int e = 0; e <= 2 + P + 1; e++) begin
            tick();
            check($sformatf("%s_edge%0d", name, e), (e >= 2 + P) ? O_OK : O_NONE);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10, 7, O_ALERT,  "t_only"};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 10, 0, O_ALERT,  "p_only"};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 10, 0, O_ALERT,  "s_only"};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10, 7, O_OK,     "back_ok"};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 10, 7, O_DANGER, "tp_danger"};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 20, 0, O_DANGER, "latch_no_fault"};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 10, 0, O_DANGER, "latch_one_fault"};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0,  5, 3, O_NONE,   "off_release"};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 10, 0, O_NONE,   "off_all_faults"};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10, 7, O_OK,     "on_ok"};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 10, 7, O_DANGER, "tps_danger"};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1,  5, 3, O_NONE,   "off_priority"};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 10, 7, O_OK,     "on_ok2"};

        // Reset state while rst is held.
        tick();
        tick();
        check("reset_state", O_NONE);

        power_up("powerup");

        // Table of steady-state windows.
        for (int v = 0; v < 13; v++) begin
            drive(vecs[v].l, vecs[v].t, vecs[v].p, vecs[v].s);
            for (int i = 0; i < vecs[v].hold; i++) begin
                tick();
                if (i >= vecs[v].chk_from)
                    check($sformatf("%s_c%0d", vecs[v].name, i), vecs[v].exp);
            end
        end

        // 3-cycle smoke glitch from steady ok is rejected.
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        for (int e = 0; e < 15; e++) begin
            if (e == 3) s = 1'b0;
            tick();
            check($sformatf("glitch3_edge%0d", e), O_OK);
        end

        // 4-cycle smoke pulse: alert after edges 6..9, ok otherwise.
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        for (int e = 0; e < 14; e++) begin
            if (e == 4) s = 1'b0;
            tick();
            check($sformatf("pulse4_edge%0d", e), (e >= 6 && e <= 9) ? O_ALERT : O_OK);
        end

        // Enter danger, then l falls: outputs clear exactly at edge 3.
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        check("pre_lfall_danger", O_DANGER);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int e = 0; e <= 4; e++) begin
            tick();
            check($sformatf("lfall_edge%0d", e), (e >= 3) ? O_NONE : O_DANGER);
        end

        // l rises with no faults: ok at edge 2+P.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int e = 0; e <= 2 + P + 1; e++) begin
            tick();
            check($sformatf("lrise_edge%0d", e), (e >= 2 + P) ? O_OK : O_NONE);
        end

        // Asynchronous reset between edges while danger is latched.
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        check("pre_rst_danger", O_DANGER);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_immediate", O_NONE);
        tick();
        check("rst_held", O_NONE);
        power_up("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
